// File: rtl/fc_pkg.sv
// Shared state encoding, default layer sizes and address-width helpers for the FC parameter store.
package fc_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_READY  = 2'd3
    } fc_state_e;

    localparam int FC_INPUT_SIZE    = 784;
    localparam int FC_OUTPUT_SIZE   = 512;
    localparam int FC_WEIGHTS_WIDTH = 8;
    localparam int FC_BIAS_WIDTH    = 32;
    localparam int FC_READ_LATENCY  = 1;

    // Address width able to index 'depth' entries; never narrower than one bit.
    function automatic int fc_addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int fc_bias_bytes(input int bias_w);
        return bias_w / 8;
    endfunction

endpackage

// File: rtl/fc_param_bank.sv
// Single-port-write, registered-read parameter memory; used once for weights and once for biases.
module fc_param_bank
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = fc_addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Kept in the plain RAM template so the array maps onto block memory; no reset on contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fc_param_store.sv
// Weight/bias store for one FullyConnected layer: byte-stream loader plus two fixed-latency read ports.
module fc_param_store
    import fc_pkg::*;
#(
    parameter int  INPUT_SIZE    = FC_INPUT_SIZE,
    parameter int  OUTPUT_SIZE   = FC_OUTPUT_SIZE,
    parameter int  WEIGHTS_WIDTH = FC_WEIGHTS_WIDTH,
    parameter int  BIAS_WIDTH    = FC_BIAS_WIDTH,
    parameter int  READ_LATENCY  = FC_READ_LATENCY,
    localparam int W_DEPTH       = INPUT_SIZE * OUTPUT_SIZE,
    localparam int W_AW          = fc_addr_w(W_DEPTH),
    localparam int B_AW          = fc_addr_w(OUTPUT_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ld_start,
    input  logic                            ld_valid,
    input  logic [7:0]                      ld_data,
    output logic                            ld_ready,
    output logic                            ld_done,
    output logic                            loaded,
    output logic                            rd_err,
    input  logic                            w_read_en,
    input  logic [W_AW-1:0]                 w_read_addr,
    output logic signed [WEIGHTS_WIDTH-1:0] w_read_data,
    input  logic                            b_read_en,
    input  logic [B_AW-1:0]                 b_read_addr,
    output logic signed [BIAS_WIDTH-1:0]    b_read_data
);

    localparam int              B_BYTES = fc_bias_bytes(BIAS_WIDTH);
    localparam int              BB_W    = fc_addr_w(B_BYTES);
    localparam logic [W_AW-1:0] W_LAST  = W_AW'(W_DEPTH - 1);
    localparam logic [B_AW-1:0] B_LAST  = B_AW'(OUTPUT_SIZE - 1);
    localparam logic [BB_W-1:0] BB_LAST = BB_W'(B_BYTES - 1);

    fc_state_e             state_q, state_d;
    logic [W_AW-1:0]       w_cnt_q, w_cnt_d;
    logic [B_AW-1:0]       b_idx_q, b_idx_d;
    logic [BB_W-1:0]       b_byte_q, b_byte_d;
    logic [BIAS_WIDTH-1:0] b_sh_q, b_sh_d;
    logic                  ld_done_q, ld_done_d;
    logic                  rd_err_q, rd_err_d;
    logic                  w_ok_p1_q, w_ok_p1_d;
    logic                  b_ok_p1_q, b_ok_p1_d;

    logic                  xfer;
    logic                  w_we, b_we;
    logic [BIAS_WIDTH-1:0] b_word;
    logic                  w_ok, b_ok;
    logic [WEIGHTS_WIDTH-1:0] w_bank_data;
    logic [BIAS_WIDTH-1:0]    b_bank_data;
    logic signed [WEIGHTS_WIDTH-1:0] w_data_p1;
    logic signed [BIAS_WIDTH-1:0]    b_data_p1;

    assign ld_ready = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B);
    assign loaded   = (state_q == ST_READY);
    assign ld_done  = ld_done_q;
    assign rd_err   = rd_err_q;

    // A restart in the same cycle as a byte drops that byte.
    assign xfer = ld_valid && ld_ready && !ld_start;

    // Little-endian assembly: each new byte enters at the top, earlier bytes slide toward bit 0.
    assign b_word = (b_sh_q >> 8) | (BIAS_WIDTH'(ld_data) << (BIAS_WIDTH - 8));

    assign w_ok = (state_q == ST_READY) && ({1'b0, w_read_addr} < (W_AW + 1)'(W_DEPTH));
    assign b_ok = (state_q == ST_READY) && ({1'b0, b_read_addr} < (B_AW + 1)'(OUTPUT_SIZE));

    always_comb begin
        state_d   = state_q;
        w_cnt_d   = w_cnt_q;
        b_idx_d   = b_idx_q;
        b_byte_d  = b_byte_q;
        b_sh_d    = b_sh_q;
        ld_done_d = 1'b0;
        w_we      = 1'b0;
        b_we      = 1'b0;
        if (ld_start) begin
            state_d  = ST_LOAD_W;
            w_cnt_d  = '0;
            b_idx_d  = '0;
            b_byte_d = '0;
        end else if (xfer) begin
            if (state_q == ST_LOAD_W) begin
                w_we = 1'b1;
                if (w_cnt_q == W_LAST) begin
                    state_d = ST_LOAD_B;
                    w_cnt_d = '0;
                end else begin
                    w_cnt_d = w_cnt_q + 1'b1;
                end
            end else begin
                b_sh_d = b_word;
                if (b_byte_q == BB_LAST) begin
                    b_we     = 1'b1;
                    b_byte_d = '0;
                    if (b_idx_q == B_LAST) begin
                        state_d   = ST_READY;
                        ld_done_d = 1'b1;
                        b_idx_d   = '0;
                    end else begin
                        b_idx_d = b_idx_q + 1'b1;
                    end
                end else begin
                    b_byte_d = b_byte_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_err_d  = rd_err_q;
        w_ok_p1_d = w_read_en ? w_ok : w_ok_p1_q;
        b_ok_p1_d = b_read_en ? b_ok : b_ok_p1_q;
        if (ld_start) begin
            rd_err_d = 1'b0;
        end else if ((w_read_en && !w_ok) || (b_read_en && !b_ok)) begin
            rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            w_cnt_q   <= '0;
            b_idx_q   <= '0;
            b_byte_q  <= '0;
            ld_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            w_ok_p1_q <= 1'b0;
            b_ok_p1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_cnt_q   <= w_cnt_d;
            b_idx_q   <= b_idx_d;
            b_byte_q  <= b_byte_d;
            ld_done_q <= ld_done_d;
            rd_err_q  <= rd_err_d;
            w_ok_p1_q <= w_ok_p1_d;
            b_ok_p1_q <= b_ok_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        b_sh_q <= b_sh_d;
    end

    fc_param_bank #(
        .WIDTH (WEIGHTS_WIDTH),
        .DEPTH (W_DEPTH),
        .AW    (W_AW)
    ) u_w_bank (
        .clk     (clk),
        .wr_en   (w_we),
        .wr_addr (w_cnt_q),
        .wr_data (WEIGHTS_WIDTH'(ld_data)),
        .rd_en   (w_read_en && w_ok),
        .rd_addr (w_read_addr),
        .rd_data (w_bank_data)
    );

    fc_param_bank #(
        .WIDTH (BIAS_WIDTH),
        .DEPTH (OUTPUT_SIZE),
        .AW    (B_AW)
    ) u_b_bank (
        .clk     (clk),
        .wr_en   (b_we),
        .wr_addr (b_idx_q),
        .wr_data (b_word),
        .rd_en   (b_read_en && b_ok),
        .rd_addr (b_read_addr),
        .rd_data (b_bank_data)
    );

    // Stage p1: bank output, forced to zero when the sampled request was illegal.
    assign w_data_p1 = w_ok_p1_q ? w_bank_data : '0;
    assign b_data_p1 = b_ok_p1_q ? b_bank_data : '0;

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic                            w_vld_p1_q, b_vld_p1_q;
            logic signed [WEIGHTS_WIDTH-1:0] w_data_p2_q, w_data_p2_d;
            logic signed [BIAS_WIDTH-1:0]    b_data_p2_q, b_data_p2_d;

            always_comb begin
                w_data_p2_d = w_data_p2_q;
                b_data_p2_d = b_data_p2_q;
                if (w_vld_p1_q) begin
                    w_data_p2_d = w_data_p1;
                end
                if (b_vld_p1_q) begin
                    b_data_p2_d = b_data_p1;
                end
            end

            // Stage p2: extra register, advanced only by a request that reached p1.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    w_vld_p1_q  <= 1'b0;
                    b_vld_p1_q  <= 1'b0;
                    w_data_p2_q <= '0;
                    b_data_p2_q <= '0;
                end else begin
                    w_vld_p1_q  <= w_read_en;
                    b_vld_p1_q  <= b_read_en;
                    w_data_p2_q <= w_data_p2_d;
                    b_data_p2_q <= b_data_p2_d;
                end
            end

            assign w_read_data = w_data_p2_q;
            assign b_read_data = b_data_p2_q;
        end else begin : g_lat1
            assign w_read_data = w_data_p1;
            assign b_read_data = b_data_p1;
        end
    endgenerate

endmodule

// File: tb/tb_fc_param_store.sv
// Scoreboard bench: latency-1 and latency-2 instances share stimulus and are checked against a byte-array model.
module tb_fc_param_store;

    localparam int IN   = 4;
    localparam int OUT  = 3;
    localparam int BW   = 32;
    localparam int NW   = IN * OUT;
    localparam int BB   = BW / 8;
    localparam int NB   = NW + OUT * BB;
    localparam int W_AW = 4;
    localparam int B_AW = 2;

    typedef struct {
        int          due;
        int          dut;
        bit          is_b;
        logic [31:0] exp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ld_start = 1'b0;
    logic            ld_valid = 1'b0;
    logic [7:0]      ld_data = 8'h00;
    logic            w_read_en = 1'b0;
    logic [W_AW-1:0] w_read_addr = '0;
    logic            b_read_en = 1'b0;
    logic [B_AW-1:0] b_read_addr = '0;

    logic        ld_ready0, ld_done0, loaded0, rd_err0;
    logic        ld_ready1, ld_done1, loaded1, rd_err1;
    logic [7:0]  w_data0, w_data1;
    logic [31:0] b_data0, b_data1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    exp_t        sbq[$];
    logic [31:0] last_v[4];
    bit          hold_en = 1'b0;

    logic [7:0]  stream[NB];
    logic [7:0]  ref_w[NW];
    logic [31:0] ref_b[OUT];
    bit          ref_loaded = 1'b0;
    bit          ref_err = 1'b0;

    fc_param_store #(
        .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .WEIGHTS_WIDTH(8), .BIAS_WIDTH(BW), .READ_LATENCY(1)
    ) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready0), .ld_done(ld_done0), .loaded(loaded0), .rd_err(rd_err0),
        .w_read_en(w_read_en), .w_read_addr(w_read_addr), .w_read_data(w_data0),
        .b_read_en(b_read_en), .b_read_addr(b_read_addr), .b_read_data(b_data0)
    );

    fc_param_store #(
        .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .WEIGHTS_WIDTH(8), .BIAS_WIDTH(BW), .READ_LATENCY(2)
    ) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready1), .ld_done(ld_done1), .loaded(loaded1), .rd_err(rd_err1),
        .w_read_en(w_read_en), .w_read_addr(w_read_addr), .w_read_data(w_data1),
        .b_read_en(b_read_en), .b_read_addr(b_read_addr), .b_read_data(b_data1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] act_of(int k);
        case (k)
            0:       return {24'b0, w_data0};
            1:       return b_data0;
            2:       return {24'b0, w_data1};
            default: return b_data1;
        endcase
    endfunction

    function automatic string name_of(int k);
        case (k)
            0:       return "w_data_lat1";
            1:       return "b_data_lat1";
            2:       return "w_data_lat2";
            default: return "b_data_lat2";
        endcase
    endfunction

    // Monitor: compare every response due this cycle; otherwise the output must hold its last value.
    always @(negedge clk) begin
        bit upd[4];
        int i;
        int idx;
        for (int k = 0; k < 4; k++) upd[k] = 1'b0;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].due <= cyc) begin
                idx = sbq[i].dut * 2 + int'(sbq[i].is_b);
                chk(name_of(idx), act_of(idx), sbq[i].exp);
                last_v[idx] = sbq[i].exp;
                upd[idx] = 1'b1;
                sbq.delete(i);
            end else begin
                i++;
            end
        end
        if (hold_en) begin
            for (int k = 0; k < 4; k++) begin
                if (!upd[k]) chk({name_of(k), "_hold"}, act_of(k), last_v[k]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push2(bit is_b, logic [31:0] e);
        exp_t t;
        t.is_b = is_b;
        t.exp  = e;
        t.dut  = 0; t.due = cyc + 1; sbq.push_back(t);
        t.dut  = 1; t.due = cyc + 2; sbq.push_back(t);
    endfunction

    function automatic void fill_s1();
        int bv[3];
        bv[0] = 100; bv[1] = -5; bv[2] = 7;
        for (int k = 0; k < NW; k++) stream[k] = 8'(k + 1);
        for (int j = 0; j < OUT; j++)
            for (int b = 0; b < BB; b++) stream[NW + j*BB + b] = 8'(bv[j] >> (8*b));
    endfunction

    function automatic void fill_rand();
        for (int k = 0; k < NB; k++) stream[k] = 8'($urandom);
    endfunction

    function automatic void model_commit();
        logic [31:0] v;
        for (int k = 0; k < NW; k++) ref_w[k] = stream[k];
        for (int j = 0; j < OUT; j++) begin
            v = '0;
            for (int b = 0; b < BB; b++) v = v | (32'(stream[NW + j*BB + b]) << (8*b));
            ref_b[j] = v;
        end
        ref_loaded = 1'b1;
    endfunction

    task automatic chk_ctrl(string tag);
        chk({tag, "_rd_err_lat1"}, 32'(rd_err0), 32'(ref_err));
        chk({tag, "_rd_err_lat2"}, 32'(rd_err1), 32'(ref_err));
        chk({tag, "_loaded_lat1"}, 32'(loaded0), 32'(ref_loaded));
        chk({tag, "_loaded_lat2"}, 32'(loaded1), 32'(ref_loaded));
    endtask

    // Restart pulse carries a byte that must be dropped; then nbytes of the stream, optionally stalled.
    task automatic do_load(input int nbytes, input bit stall);
        int  i;
        int  waits;
        bit  ph;
        bit  rdy;
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
        ref_loaded = 1'b0; ref_err = 1'b0;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        chk("ld_ready_after_start", 32'({ld_ready1, ld_ready0}), 32'h3);
        i = 0; waits = 0; ph = 1'b0;
        while (i < nbytes && waits < 200) begin
            ph = stall ? ~ph : 1'b1;
            ld_valid = ph;
            ld_data  = ph ? stream[i] : 8'($urandom);
            rdy = ld_ready0;
            tick();
            if (ph && rdy) begin
                i++;
                chk("ld_done_lat1", 32'(ld_done0), 32'(i == NB));
                chk("ld_done_lat2", 32'(ld_done1), 32'(i == NB));
            end else begin
                waits++;
            end
        end
        ld_valid = 1'b0;
        if (i < nbytes) chk("load_stream_timeout", 32'(i), 32'(nbytes));
        if (nbytes == NB) begin
            model_commit();
            chk("ld_ready_after_done", 32'({ld_ready1, ld_ready0}), 32'h0);
            chk("loaded_after_done", 32'({loaded1, loaded0}), 32'h3);
            tick();
            chk("ld_done_pulse_end", 32'({ld_done1, ld_done0}), 32'h0);
        end
    endtask

    task automatic rd(input bit we, input int wa, input bit be, input int ba);
        logic [31:0] e;
        w_read_en = we; w_read_addr = W_AW'(wa);
        b_read_en = be; b_read_addr = B_AW'(ba);
        if (we) begin
            e = '0;
            if (ref_loaded && wa < NW) e = {24'b0, ref_w[wa]};
            else ref_err = 1'b1;
            push2(1'b0, e);
        end
        if (be) begin
            e = '0;
            if (ref_loaded && ba < OUT) e = ref_b[ba];
            else ref_err = 1'b1;
            push2(1'b1, e);
        end
        tick();
    endtask

    task automatic idle(input int n);
        w_read_en = 1'b0; b_read_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic read_all();
        for (int a = 0; a < NW; a++) rd(1'b1, a, a < OUT, a % OUT);
        idle(3);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_ld_ready"}, 32'({ld_ready1, ld_ready0}), 32'h0);
        chk({tag, "_ld_done"},  32'({ld_done1, ld_done0}), 32'h0);
        chk({tag, "_loaded"},   32'({loaded1, loaded0}), 32'h0);
        chk({tag, "_rd_err"},   32'({rd_err1, rd_err0}), 32'h0);
        chk({tag, "_w_data"},   {16'b0, w_data1, w_data0}, 32'h0);
        chk({tag, "_b_data"},   b_data0 | b_data1, 32'h0);
    endtask

    task automatic apply_reset();
        hold_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("reset");
        ref_loaded = 1'b0; ref_err = 1'b0;
        for (int k = 0; k < 4; k++) last_v[k] = '0;
        hold_en = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        apply_reset();

        // Reads while EMPTY are illegal.
        rd(1'b1, 5, 1'b1, 1);
        idle(3);
        chk_ctrl("empty_read");

        // Known stream, then the two fixed-value reads.
        fill_s1();
        do_load(NB, 1'b0);
        chk_ctrl("s1_loaded");
        w_read_en = 1'b1; w_read_addr = W_AW'(5); push2(1'b0, 32'h0000_0006);
        b_read_en = 1'b1; b_read_addr = B_AW'(1); push2(1'b1, 32'hFFFF_FFFB);
        tick();
        idle(3);

        // Back-to-back reads on both ports.
        read_all();
        chk_ctrl("b2b");

        // Out-of-range addresses after a full load.
        rd(1'b1, 12, 1'b1, 3);
        idle(3);
        chk_ctrl("oob_read");

        // Partial load: restart clears rd_err, reads during LOAD_W are illegal.
        do_load(3, 1'b0);
        chk_ctrl("partial_start");
        rd(1'b1, 0, 1'b1, 0);
        idle(3);
        chk_ctrl("load_w_read");

        // Restart after byte 7, then a full load.
        fill_rand();
        do_load(7, 1'b0);
        fill_s1();
        do_load(NB, 1'b0);
        read_all();
        chk_ctrl("restart");

        // Stalled stream must land the same contents.
        fill_s1();
        do_load(NB, 1'b1);
        read_all();
        chk_ctrl("stalled");

        // Random contents and random traffic, including illegal addresses.
        repeat (3) begin
            fill_rand();
            do_load(NB, 1'($urandom_range(0, 1)));
            repeat (40) rd(1'($urandom_range(0, 1)), int'($urandom_range(0, 13)),
                           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            idle(3);
            chk_ctrl("random");
        end

        // Reset in the middle of LOAD_B.
        fill_rand();
        do_load(NW + 2, 1'b0);
        idle(3);
        apply_reset();
        ld_valid = 1'b1; ld_data = 8'h5A;
        repeat (3) begin
            tick();
            chk("post_reset_ld_ready", 32'({ld_ready1, ld_ready0}), 32'h0);
            chk("post_reset_loaded", 32'({loaded1, loaded0}), 32'h0);
        end
        ld_valid = 1'b0;
        rd(1'b1, 1, 1'b0, 0);
        idle(3);
        chk_ctrl("post_reset_read");
        do_load(NB, 1'b0);
        read_all();
        chk_ctrl("reload");

        idle(4);
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
